ram4k: RTL and testbench



---
 rtl/ram4k_pkg.sv | 27 ++
 rtl/ram4k_ram512.sv | 37 +++
 rtl/ram4k.sv | 53 +++++
 tb/tb_ram4k.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram4k_pkg.sv
// ram4k_pkg: shared widths, depths and typedefs for the 4K-word memory and
// its 512-word banks, plus helpers that split a word address into bank
// select and in-bank offset.
package ram4k_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 12;
  localparam int DEPTH       = 2 ** ADDR_W;
  localparam int BANK_ADDR_W = 9;
  localparam int BANK_DEPTH  = 2 ** BANK_ADDR_W;
  localparam int NUM_BANKS   = DEPTH / BANK_DEPTH;
  localparam int BANK_SEL_W  = ADDR_W - BANK_ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Upper address bits pick the bank.
  function automatic logic [BANK_SEL_W-1:0] bank_sel(input addr_t a);
    return a[ADDR_W-1:BANK_ADDR_W];
  endfunction

  // Lower address bits pick the word inside the bank.
  function automatic logic [BANK_ADDR_W-1:0] bank_off(input addr_t a);
    return a[BANK_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/ram4k_ram512.sv
// ram4k_ram512: one 512 x DATA_W bank. Asynchronous clear of every word,
// synchronous write on load, combinational read of the addressed word.
// The clear-all reset means storage is flops, not block RAM.
module ram4k_ram512
  import ram4k_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BANK_ADDR_W-1:0] address,
  input  word_t                  in,
  input  logic                   load,
  output word_t                  out
);

  word_t mem_q [BANK_DEPTH];
  word_t mem_d [BANK_DEPTH];

  // Next-state memory: unchanged except the addressed word when load is high.
  always_comb begin
    mem_d = mem_q;
    if (load) begin
      mem_d[address] = in;
    end
  end

  // Storage register: reset clears every word at once, independent of clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign out = mem_q[address];

endmodule

// File: rtl/ram4k.sv
// ram4k: 4096 x DATA_W memory built from eight 512-word banks.
// address[11:9] selects the bank (load demux and output mux),
// address[8:0] selects the word inside the bank.
// Optional macro RAM4K_WRITE_THROUGH_EN: while load=1 and reset=0, out
// follows in combinationally; storage and write timing are unchanged.
module ram4k
  import ram4k_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  addr_t address,
  input  word_t in,
  input  logic  load,
  output word_t out
);

  logic [NUM_BANKS-1:0]  bank_load;
  word_t                 bank_out [NUM_BANKS];
  logic [BANK_SEL_W-1:0] sel;
  word_t                 read_data;

  assign sel = bank_sel(address);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      // Only the selected bank sees load, so other banks never change.
      assign bank_load[gi] = load && (sel == BANK_SEL_W'(gi));

      ram4k_ram512 u_bank (
        .clk     (clk),
        .reset   (reset),
        .address (bank_off(address)),
        .in      (in),
        .load    (bank_load[gi]),
        .out     (bank_out[gi])
      );
    end
  endgenerate

  // Output mux: present the selected bank's word.
  always_comb begin
    read_data = bank_out[sel];
  end

`ifdef RAM4K_WRITE_THROUGH_EN
  // Write-through: pending write data is visible before the clock edge.
  assign out = (load && !reset) ? in : read_data;
`else
  assign out = read_data;
`endif

endmodule

// File: tb/tb_ram4k.sv
// tb_ram4k: directed self-checking bench for ram4k. Inputs change on the
// falling edge; outputs are sampled 1 time unit after settling.
module tb_ram4k;

  logic        clk;
  logic        reset;
  logic [11:0] address;
  logic [15:0] in;
  logic        load;
  logic [15:0] out;

  int checks;
  int errors;

  ram4k dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .in      (in),
    .load    (load),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write: set up on the falling edge, commit on the rising edge.
  task automatic do_write(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    $display("write addr=%0d data=0x%04h", a, d);
  endtask

  task automatic test_reset;
    logic [11:0] addrs [4];
    addrs = '{12'd0, 12'd3, 12'd7, 12'd4095};
    // Power-on state after a reset pulse.
    reset = 1'b1; load = 1'b0; address = '0; in = '0;
    #12;
    reset = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000) begin
      $display("FAIL reset_initial: out=0x%04h expected 0x0000", out); errors++;
    end
    do_write(12'd0, 16'hAAAA);
    do_write(12'd4095, 16'h5555);
    address = 12'd0; #1;
    checks++;
    if (out !== 16'hAAAA) begin
      $display("FAIL pre_reset_0: out=0x%04h expected 0xAAAA", out); errors++;
    end
    address = 12'd4095; #1;
    checks++;
    if (out !== 16'h5555) begin
      $display("FAIL pre_reset_4095: out=0x%04h expected 0x5555", out); errors++;
    end
    // Assert reset between edges: clear must be immediate.
    @(negedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = addrs[i];
      #0.5;
      checks++;
      if (out !== 16'h0000) begin
        $display("FAIL reset_async addr=%0d: out=0x%04h expected 0x0000", addrs[i], out);
        errors++;
      end
      $display("reset read addr=%0d out=0x%04h", addrs[i], out);
    end
    // Writes are ignored while reset is high.
    address = 12'd5; in = 16'hBEEF; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000) begin
      $display("FAIL reset_blocks_write: out=0x%04h expected 0x0000", out); errors++;
    end
  endtask

  task automatic test_write_clear_0;
    do_write(12'd0, 16'h3524);
    address = 12'd0; #1;
    checks++;
    if (out !== 16'h3524) begin
      $display("FAIL write_0: out=0x%04h expected 0x3524", out); errors++;
    end
    do_write(12'd0, 16'h0000);
    checks++;
    if (out !== 16'h0000) begin
      $display("FAIL clear_0: out=0x%04h expected 0x0000", out); errors++;
    end
  endtask

  task automatic test_write_clear_3_7;
    do_write(12'd3, 16'h5E81);
    do_write(12'd7, 16'hD609);
    address = 12'd3; #1;
    checks++;
    if (out !== 16'h5E81) begin
      $display("FAIL write_3: out=0x%04h expected 0x5E81", out); errors++;
    end
    address = 12'd7; #1;
    checks++;
    if (out !== 16'hD609) begin
      $display("FAIL write_7: out=0x%04h expected 0xD609", out); errors++;
    end
    address = 12'd0; #1;
    checks++;
    if (out !== 16'h0000) begin
      $display("FAIL untouched_0: out=0x%04h expected 0x0000", out); errors++;
    end
    do_write(12'd3, 16'h0000);
    do_write(12'd7, 16'h0000);
    address = 12'd3; #1;
    checks++;
    if (out !== 16'h0000) begin
      $display("FAIL clear_3: out=0x%04h expected 0x0000", out); errors++;
    end
    address = 12'd7; #1;
    checks++;
    if (out !== 16'h0000) begin
      $display("FAIL clear_7: out=0x%04h expected 0x0000", out); errors++;
    end
  endtask

  task automatic test_top_address;
    do_write(12'd4095, 16'h5663);
    address = 12'd4095; #1;
    checks++;
    if (out !== 16'h5663) begin
      $display("FAIL write_4095: out=0x%04h expected 0x5663", out); errors++;
    end
    address = 12'd511; #1;
    checks++;
    if (out !== 16'h0000) begin
      $display("FAIL alias_511: out=0x%04h expected 0x0000", out); errors++;
    end
  endtask

  task automatic test_load_low;
    do_write(12'd4095, 16'h0000);
    @(negedge clk);
    address = 12'd4095; in = 16'h7B0D; load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000) begin
      $display("FAIL load_low_4095: out=0x%04h expected 0x0000", out); errors++;
    end
    $display("load-low read addr=4095 out=0x%04h", out);
    address = 12'd0; #1;
    checks++;
    if (out !== 16'h0000) begin
      $display("FAIL load_low_0: out=0x%04h expected 0x0000", out); errors++;
    end
  endtask

  task automatic test_bank_isolation;
    logic [11:0] addrs [3];
    logic [15:0] exp   [3];
    addrs = '{12'd512, 12'd1024, 12'd0};
    exp   = '{16'h1111, 16'h2222, 16'h0000};
    do_write(12'd512, 16'h1111);
    do_write(12'd1024, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      address = addrs[i]; #1;
      checks++;
      if (out !== exp[i]) begin
        $display("FAIL bank_iso addr=%0d: out=0x%04h expected 0x%04h", addrs[i], out, exp[i]);
        errors++;
      end
      $display("bank read addr=%0d out=0x%04h", addrs[i], out);
    end
  endtask

  task automatic test_read_during_write;
    logic [15:0] exp_before;
    do_write(12'd100, 16'h0ABC);
    @(negedge clk);
    address = 12'd100; in = 16'h1234; load = 1'b1;
    #1;
`ifdef RAM4K_WRITE_THROUGH_EN
    exp_before = 16'h1234;
`else
    exp_before = 16'h0ABC;
`endif
    checks++;
    if (out !== exp_before) begin
      $display("FAIL rdw_before: out=0x%04h expected 0x%04h", out, exp_before); errors++;
    end
    @(posedge clk); #1;
    load = 1'b0;
    #1;
    checks++;
    if (out !== 16'h1234) begin
      $display("FAIL rdw_after: out=0x%04h expected 0x1234", out); errors++;
    end
    $display("rdw addr=100 out=0x%04h", out);
  endtask

  task automatic test_address_change;
    // Combinational read: out tracks address without a clock edge.
    address = 12'd512; #1;
    checks++;
    if (out !== 16'h1111) begin
      $display("FAIL addr_change_512: out=0x%04h expected 0x1111", out); errors++;
    end
    address = 12'd1024; #1;
    checks++;
    if (out !== 16'h2222) begin
      $display("FAIL addr_change_1024: out=0x%04h expected 0x2222", out); errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_clear_0();
    test_write_clear_3_7();
    test_top_address();
    test_load_low();
    test_bank_isolation();
    test_read_during_write();
    test_address_change();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
